sca_sendback_queue: RTL and testbench

- Parametrised successor to the single-reply SCA sendback block.
- Buffers up to FIFO_DEPTH GBT-SCA replies in an internal queue and serialises each one, byte by byte, onto the UART TX byte interface.
- Frames each packet with an optional sync byte and an optional XOR checksum.
- Counts replies dropped on overflow; sits between the SCA RX decoder and the UART TX core.

---
 rtl/sca_sendback_queue.sv | 165 ++++++++++++++++
 tb/tb_sca_sendback_queue.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sca_sendback_queue.sv
// Queues GBT-SCA replies and serialises each one as a framed byte packet
// ([sync] address transID channel error len data [xor checksum]) onto a UART TX byte port.
module sca_sendback_queue #(
  parameter int         DATA_BYTES  = 4,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         SYNC_EN     = 1,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         CHECKSUM_EN = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            send_enable,
  input  logic                            rx_reply_received,
  input  logic [7:0]                      rx_address,
  input  logic [7:0]                      rx_transID,
  input  logic [7:0]                      rx_channel,
  input  logic [7:0]                      rx_len,
  input  logic [7:0]                      rx_error,
  input  logic [8*DATA_BYTES-1:0]         rx_data,
  input  logic                            uart_tx_ready,
  input  logic                            overflow_clr,
  output logic [7:0]                      uart_data,
  output logic                            uart_data_write,
  output logic                            sca_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow,
  output logic [7:0]                      drop_count
);

  localparam int REC_W   = 40 + 8*DATA_BYTES;
  localparam int CW      = $clog2(FIFO_DEPTH+1);
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam bit HAS_SYNC = (SYNC_EN != 0);
  localparam bit HAS_CHK  = (CHECKSUM_EN != 0);
  localparam int PKT_LEN = (HAS_SYNC ? 1 : 0) + 5 + DATA_BYTES + (HAS_CHK ? 1 : 0);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_ENABLE, SEND, GAP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [REC_W-1:0] shift_q, shift_d;
  logic [4:0]       left_q, left_d;
  logic [7:0]       chk_q, chk_d, data_q, data_d, drop_q, drop_d;
  logic             write_q, write_d, busy_q, busy_d, ovf_q, ovf_d;

  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [REC_W-1:0] head_q;
  logic             pop, push_ok, drop;
  logic [7:0]       field_byte;

  assign pop        = (state_q == LOAD);
  assign push_ok    = rx_reply_received && ((count_q < CW'(FIFO_DEPTH)) || pop);
  assign drop       = rx_reply_received && !push_ok;
  assign field_byte = shift_q[REC_W-1 -: 8];

  // The head is read one cycle ahead: IDLE always precedes LOAD, so head_q is
  // valid when LOAD consumes it.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr_q] <= {rx_address, rx_transID, rx_channel, rx_error, rx_len, rx_data};
    end
    head_q <= mem[rptr_q];
  end

  always_comb begin
    wptr_d  = push_ok ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (overflow_clr) begin
      ovf_d  = 1'b0;
      drop_d = 8'd0;
    end else begin
      ovf_d  = ovf_q | drop;
      drop_d = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end

    busy_d  = (count_q != '0) || (state_q != IDLE);
    state_d = state_q;
    shift_d = shift_q;
    left_d  = left_q;
    chk_d   = chk_q;
    data_d  = 8'd0;
    write_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = LOAD;
      end
      LOAD: begin
        shift_d = head_q;
        left_d  = 5'(PKT_LEN);
        chk_d   = 8'd0;
        state_d = WAIT_ENABLE;
      end
      WAIT_ENABLE: begin
        if (send_enable) state_d = SEND;
      end
      SEND: begin
        if (uart_tx_ready) begin
          write_d = 1'b1;
          left_d  = left_q - 5'd1;
          state_d = GAP;
          if (HAS_SYNC && left_q == 5'(PKT_LEN)) begin
            data_d = SYNC_BYTE;
          end else if (HAS_CHK && left_q == 5'd1) begin
            data_d = chk_q;
          end else begin
            data_d  = field_byte;
            chk_d   = chk_q ^ field_byte;
            shift_d = shift_q << 8;
          end
        end
      end
      GAP: begin
        state_d = (left_q == 5'd0) ? IDLE : SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      shift_q <= '0;
      left_q  <= 5'd0;
      chk_q   <= 8'd0;
      data_q  <= 8'd0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      shift_q <= shift_d;
      left_q  <= left_d;
      chk_q   <= chk_d;
      data_q  <= data_d;
      write_q <= write_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign uart_data       = data_q;
  assign uart_data_write = write_q;
  assign sca_busy        = busy_q;
  assign fifo_count      = count_q;
  assign overflow        = ovf_q;
  assign drop_count      = drop_q;

endmodule

// File: tb/tb_sca_sendback_queue.sv
// Scoreboard bench for sca_sendback_queue: a default instance (A) and a
// DATA_BYTES=2, no-sync, no-checksum instance (B).
module tb_sca_sendback_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_en, a_rx, a_ready, a_clr;
  logic [7:0]  a_addr, a_tid, a_ch, a_len, a_err;
  logic [31:0] a_dat;
  logic [7:0]  a_udata, a_drop;
  logic        a_uwr, a_busy, a_ovf;
  logic [2:0]  a_cnt;

  logic        b_en, b_rx, b_ready, b_clr;
  logic [7:0]  b_addr, b_tid, b_ch, b_len, b_err;
  logic [15:0] b_dat;
  logic [7:0]  b_udata, b_drop;
  logic        b_uwr, b_busy, b_ovf;
  logic [2:0]  b_cnt;

  sca_sendback_queue dut_a (
    .clk(clk), .rst_n(rst_n), .send_enable(a_en), .rx_reply_received(a_rx),
    .rx_address(a_addr), .rx_transID(a_tid), .rx_channel(a_ch), .rx_len(a_len),
    .rx_error(a_err), .rx_data(a_dat), .uart_tx_ready(a_ready), .overflow_clr(a_clr),
    .uart_data(a_udata), .uart_data_write(a_uwr), .sca_busy(a_busy),
    .fifo_count(a_cnt), .overflow(a_ovf), .drop_count(a_drop)
  );

  sca_sendback_queue #(
    .DATA_BYTES(2), .FIFO_DEPTH(4), .SYNC_EN(0), .SYNC_BYTE(8'hA5), .CHECKSUM_EN(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .send_enable(b_en), .rx_reply_received(b_rx),
    .rx_address(b_addr), .rx_transID(b_tid), .rx_channel(b_ch), .rx_len(b_len),
    .rx_error(b_err), .rx_data(b_dat), .uart_tx_ready(b_ready), .overflow_clr(b_clr),
    .uart_data(b_udata), .uart_data_write(b_uwr), .sca_busy(b_busy),
    .fifo_count(b_cnt), .overflow(b_ovf), .drop_count(b_drop)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int a_wr_count = 0, b_wr_count = 0;
  int a_last = -1, b_last = -1;
  bit a_hold = 1'b0;
  int a_hold_writes = 0;
  bit a_lat_pending = 1'b0;
  int a_strobe_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected default-instance packet: A5, header, data MSB first, XOR checksum.
  task automatic push_pkt_a(input logic [7:0] ad, t, c, e, l, input logic [31:0] d);
    logic [7:0] cs;
    cs = ad ^ t ^ c ^ e ^ l;
    exp_a.push_back(8'hA5);
    exp_a.push_back(ad); exp_a.push_back(t); exp_a.push_back(c);
    exp_a.push_back(e);  exp_a.push_back(l);
    for (int i = 3; i >= 0; i--) begin
      exp_a.push_back(d[8*i +: 8]);
      cs = cs ^ d[8*i +: 8];
    end
    exp_a.push_back(cs);
  endtask

  task automatic strobe_a(input logic [7:0] ad, t, c, e, l, input logic [31:0] d,
                          input bit accepted);
    a_addr = ad; a_tid = t; a_ch = c; a_err = e; a_len = l; a_dat = d;
    a_rx = 1'b1;
    if (accepted) push_pkt_a(ad, t, c, e, l, d);
    @(negedge clk);
    a_rx = 1'b0;
  endtask

  task automatic strobe_b(input logic [7:0] ad, t, c, e, l, input logic [15:0] d);
    b_addr = ad; b_tid = t; b_ch = c; b_err = e; b_len = l; b_dat = d;
    b_rx = 1'b1;
    @(negedge clk);
    b_rx = 1'b0;
  endtask

  task automatic wait_wr_a(input int target);
    int g = 0;
    while (a_wr_count < target && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("a_wait_bytes_reached", 32'(a_wr_count >= target), 32'd1);
  endtask

  task automatic drain_a(input string name);
    int g = 0;
    while ((exp_a.size() != 0 || a_cnt != 3'd0 || a_busy) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk({name, "_drained"}, 32'(exp_a.size()), 32'd0);
    chk({name, "_fifo_count"}, 32'(a_cnt), 32'd0);
    chk({name, "_busy_fell"}, 32'(a_busy), 32'd0);
  endtask

  // Monitor A: every written byte is popped from the scoreboard and compared.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (a_uwr) begin
      if (exp_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_byte: got unexpected byte %0h, expected none", a_udata);
      end else begin
        chk("a_byte", 32'(a_udata), 32'(exp_a.pop_front()));
      end
      if (a_last >= 0) chk("a_byte_spacing_ge2", 32'(cyc - a_last >= 2), 32'd1);
      if (a_lat_pending) begin
        chk("a_first_byte_latency_ge4", 32'(cyc - a_strobe_cyc >= 4), 32'd1);
        a_lat_pending = 1'b0;
      end
      a_last = cyc;
      a_wr_count++;
      if (a_hold) a_hold_writes++;
    end else if (a_udata !== 8'd0) begin
      chk("a_data_zero_when_idle", 32'(a_udata), 32'd0);
    end
  end

  always @(posedge clk) begin
    #1;
    if (b_uwr) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_byte: got unexpected byte %0h, expected none", b_udata);
      end else begin
        chk("b_byte", 32'(b_udata), 32'(exp_b.pop_front()));
      end
      if (b_last >= 0) chk("b_byte_spacing_ge2", 32'(cyc - b_last >= 2), 32'd1);
      b_last = cyc;
      b_wr_count++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [7:0] tbl1 [11];
    tbl1 = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h26};

    rst_n = 1'b0;
    a_en = 0; a_rx = 0; a_ready = 0; a_clr = 0;
    a_addr = 0; a_tid = 0; a_ch = 0; a_len = 0; a_err = 0; a_dat = 0;
    b_en = 0; b_rx = 0; b_ready = 0; b_clr = 0;
    b_addr = 0; b_tid = 0; b_ch = 0; b_len = 0; b_err = 0; b_dat = 0;
    repeat (3) @(negedge clk);
    chk("reset_uart_write", 32'(a_uwr), 32'd0);
    chk("reset_uart_data", 32'(a_udata), 32'd0);
    chk("reset_busy", 32'(a_busy), 32'd0);
    chk("reset_fifo_count", 32'(a_cnt), 32'd0);
    chk("reset_overflow", 32'(a_ovf), 32'd0);
    chk("reset_drop_count", 32'(a_drop), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single reply with a hand-computed packet (checksum 0x26).
    a_en = 1; a_ready = 1;
    for (int i = 0; i < 11; i++) exp_a.push_back(tbl1[i]);
    a_strobe_cyc = cyc + 1;
    a_lat_pending = 1'b1;
    strobe_a(8'h01, 8'h02, 8'h03, 8'h00, 8'h04, 32'hDEADBEEF, 1'b0);
    drain_a("t1");

    // Enable low: the first record parks in the shift register, then six
    // back-to-back strobes fill the queue and drop two.
    a_en = 0;
    strobe_a(8'h10, 8'h11, 8'h12, 8'h00, 8'h04, 32'h0102_0304, 1'b1);
    repeat (5) @(negedge clk);
    chk("t2_parked_count", 32'(a_cnt), 32'd0);
    strobe_a(8'h20, 8'h21, 8'h22, 8'h00, 8'h04, 32'hA0A1_A2A3, 1'b1);
    strobe_a(8'h30, 8'h31, 8'h32, 8'h01, 8'h04, 32'hB0B1_B2B3, 1'b1);
    strobe_a(8'h40, 8'h41, 8'h42, 8'h02, 8'h04, 32'hC0C1_C2C3, 1'b1);
    strobe_a(8'h50, 8'h51, 8'h52, 8'h03, 8'h04, 32'hD0D1_D2D3, 1'b1);
    strobe_a(8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 32'h6666_6666, 1'b0);
    strobe_a(8'h77, 8'h77, 8'h77, 8'h77, 8'h77, 32'h7777_7777, 1'b0);
    chk("t2_fifo_count_full", 32'(a_cnt), 32'd4);
    chk("t2_overflow", 32'(a_ovf), 32'd1);
    chk("t2_drop_count", 32'(a_drop), 32'd2);
    chk("t2_no_bytes_while_disabled", 32'(exp_a.size()), 32'd55);
    a_en = 1;
    drain_a("t2");

    // Ready held low for 20 cycles after the 5th byte.
    base = a_wr_count;
    strobe_a(8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 32'h1234_5678, 1'b1);
    wait_wr_a(base + 5);
    a_ready = 0;
    a_hold = 1'b1;
    repeat (20) @(negedge clk);
    a_hold = 1'b0;
    chk("t3_no_writes_during_hold", 32'(a_hold_writes), 32'd0);
    chk("t3_remaining_bytes", 32'(exp_a.size()), 32'd6);
    a_ready = 1;
    drain_a("t3");

    // Asynchronous reset after the 5th byte of a packet.
    base = a_wr_count;
    strobe_a(8'h91, 8'h92, 8'h93, 8'h94, 8'h95, 32'hCAFE_F00D, 1'b1);
    strobe_a(8'h99, 8'h99, 8'h99, 8'h99, 8'h99, 32'h9999_9999, 1'b0);
    wait_wr_a(base + 5);
    rst_n = 1'b0;
    #1;
    chk("t4_async_write_clear", 32'(a_uwr), 32'd0);
    chk("t4_async_data_clear", 32'(a_udata), 32'd0);
    chk("t4_async_busy_clear", 32'(a_busy), 32'd0);
    chk("t4_async_fifo_empty", 32'(a_cnt), 32'd0);
    exp_a.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t4_no_bytes_after_reset", 32'(a_wr_count), 32'(base + 5));
    strobe_a(8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h04, 32'h0BAD_CAFE, 1'b1);
    drain_a("t4");

    // Full queue: a drop, then a strobe in the LOAD pop cycle is accepted,
    // then overflow_clr wins over a simultaneous drop.
    a_ready = 0;
    strobe_a(8'hB0, 8'hB1, 8'hB2, 8'h00, 8'h04, 32'h1111_2222, 1'b1);
    repeat (4) @(negedge clk);
    strobe_a(8'hC1, 8'h01, 8'h00, 8'h00, 8'h04, 32'h0000_0001, 1'b1);
    strobe_a(8'hC2, 8'h02, 8'h00, 8'h00, 8'h04, 32'h0000_0002, 1'b1);
    strobe_a(8'hC3, 8'h03, 8'h00, 8'h00, 8'h04, 32'h0000_0003, 1'b1);
    strobe_a(8'hC4, 8'h04, 8'h00, 8'h00, 8'h04, 32'h0000_0004, 1'b1);
    strobe_a(8'hC5, 8'h05, 8'h00, 8'h00, 8'h04, 32'h0000_0005, 1'b0);
    chk("t5_full_count", 32'(a_cnt), 32'd4);
    chk("t5_overflow_set", 32'(a_ovf), 32'd1);
    chk("t5_drop_one", 32'(a_drop), 32'd1);
    base = a_wr_count;
    a_ready = 1;
    wait_wr_a(base + 11);
    @(negedge clk);
    @(negedge clk);
    chk("t5_full_at_load", 32'(a_cnt), 32'd4);
    strobe_a(8'hC6, 8'h06, 8'h00, 8'h00, 8'h04, 32'h0000_0006, 1'b1);
    chk("t5_load_push_count", 32'(a_cnt), 32'd4);
    chk("t5_load_push_no_drop", 32'(a_drop), 32'd1);
    a_clr = 1;
    strobe_a(8'hC7, 8'h07, 8'h00, 8'h00, 8'h04, 32'h0000_0007, 1'b0);
    a_clr = 0;
    chk("t5_clr_overflow", 32'(a_ovf), 32'd0);
    chk("t5_clr_drop_count", 32'(a_drop), 32'd0);
    chk("t5_clr_count_still_full", 32'(a_cnt), 32'd4);
    drain_a("t5");

    // Instance B: 7-byte packets, no sync and no checksum.
    b_en = 1; b_ready = 1;
    exp_b.push_back(8'h11); exp_b.push_back(8'h22); exp_b.push_back(8'h33);
    exp_b.push_back(8'h44); exp_b.push_back(8'h02); exp_b.push_back(8'hBE);
    exp_b.push_back(8'hEF);
    exp_b.push_back(8'h55); exp_b.push_back(8'h66); exp_b.push_back(8'h77);
    exp_b.push_back(8'h00); exp_b.push_back(8'h02); exp_b.push_back(8'h12);
    exp_b.push_back(8'h34);
    strobe_b(8'h11, 8'h22, 8'h33, 8'h44, 8'h02, 16'hBEEF);
    strobe_b(8'h55, 8'h66, 8'h77, 8'h00, 8'h02, 16'h1234);
    for (int g = 0; g < 500 && (exp_b.size() != 0 || b_busy); g++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("b_total_bytes", 32'(b_wr_count), 32'd14);
    chk("b_fifo_empty", 32'(b_cnt), 32'd0);
    chk("b_busy_low", 32'(b_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
